seq_pattern_gen: RTL and testbench

//  Serial pattern transmitter: loads a PAT_W-bit pattern, shifts it out MSB-first on a
//  1-bit stream, repeated a programmed number of times. Transmit-side counterpart of the

---
 rtl/seq_gen_pkg.sv | 17 +
 rtl/seq_pattern_gen_if.sv | 34 +++
 rtl/seq_pattern_gen_piso_shift.sv | 43 ++++
 rtl/seq_pattern_gen.sv | 201 ++++++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator.
// Contents:
//   STATE_W  - width of the FSM state encoding
//   state_t  - FSM states IDLE / SHIFT / GAP / DONE
// GAP is only reachable when the design is built with PATTERN_GAP_EN defined.
package seq_gen_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle of the serial pattern generator.
// Signals:
//   start      request, sampled by the generator only while idle
//   pattern    PAT_W-bit pattern, captured on an accepted start
//   reps       repetition count, captured on an accepted start
//   ser_out    serial data, pattern MSB first
//   ser_valid  ser_out carries a pattern bit this cycle
//   busy       a job is in progress
//   done       single-cycle completion pulse
// Modports: master drives the request side, slave (the generator) drives the stream.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) ();

    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, reps,
        input  ser_out, ser_valid, busy, done
    );

    modport slave (
        input  start, pattern, reps,
        output ser_out, ser_valid, busy, done
    );

endinterface

// File: rtl/seq_pattern_gen_piso_shift.sv
// piso_shift: parallel-in serial-out shift register, shifting left (MSB leaves first).
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      parallel load of din (has priority over shift)
//   shift     shift one position left, zero enters at bit 0
//   din       parallel load value
//   msb_next  MSB the register will hold after the coming clock edge; lets the
//             owner register the serial output in the same cycle as the shift
module piso_shift #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb_next
);

    logic [W-1:0] shreg_reg;
    logic [W-1:0] shreg_next;

    assign shreg_next[0] = load ? din[0] : (shift ? 1'b0 : shreg_reg[0]);

    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_stage
            assign shreg_next[gi] = load  ? din[gi]
                                  : shift ? shreg_reg[gi-1]
                                  :         shreg_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg <= '0;
        end else begin
            shreg_reg <= shreg_next;
        end
    end

    assign msb_next = shreg_next[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter. Captures a PAT_W-bit pattern and a
// repetition count on start, then shifts the pattern out MSB first, reps times.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   seq_pattern_gen_if.slave (start/pattern/reps in; ser_out/ser_valid/busy/done out)
// Build option: define PATTERN_GAP_EN to insert GAP_BITS idle cycles between
// repetitions (never after the last one). Without it repetitions are contiguous.
// All outputs are registered; each is computed from the next state so that the
// first bit appears the cycle right after start is sampled.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W    = 4,
    parameter int CNT_W    = 8,
    parameter int GAP_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    seq_pattern_gen_if.slave    bus
);

    localparam int BIT_W = $clog2(PAT_W);

    state_t             state_reg, state_next;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic [CNT_W-1:0]   rep_cnt_reg;
    logic [PAT_W-1:0]   hold_reg;

    logic               load_en;
    logic               shift_en;
    logic [PAT_W-1:0]   piso_din;
    logic               msb_next;

    logic               ser_out_reg,   ser_out_next;
    logic               ser_valid_reg, ser_valid_next;
    logic               busy_reg,      busy_next;
    logic               done_reg,      done_next;

    logic               accept;
    logic               last_bit;
    logic               last_rep;

    assign accept   = (state_reg == IDLE) && bus.start && (bus.reps != '0);
    assign last_bit = (bit_cnt_reg == '0);
    assign last_rep = (rep_cnt_reg == CNT_W'(1));

`ifdef PATTERN_GAP_EN
    // A zero-length gap degenerates to contiguous repetitions.
    localparam bit GAP_ON = (GAP_BITS != 0);
    localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    logic [GAP_W-1:0] gap_cnt_reg;
    logic             gap_last;

    assign gap_last = (gap_cnt_reg == GAP_W'(GAP_BITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt_reg <= '0;
        end else if (state_reg == GAP && !gap_last) begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
        end else begin
            gap_cnt_reg <= '0;
        end
    end
`else
    // GAP_BITS has no meaning without gap support; tie it off.
    logic [31:0] unused_gap_bits;
    assign unused_gap_bits = 32'(GAP_BITS);
`endif

    piso_shift #(
        .W (PAT_W)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (load_en),
        .shift    (shift_en),
        .din      (piso_din),
        .msb_next (msb_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and shift-register control
    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        piso_din   = hold_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.reps != '0) begin
                        state_next = SHIFT;
                        load_en    = 1'b1;
                        piso_din   = bus.pattern;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shift_en = 1'b1;
                end else if (last_rep) begin
                    state_next = DONE;
                end else begin
                    // Reload from the hold copy so the next repetition starts
                    // with the pattern MSB without a bubble.
                    load_en = 1'b1;
`ifdef PATTERN_GAP_EN
                    state_next = GAP_ON ? GAP : SHIFT;
`else
                    state_next = SHIFT;
`endif
                end
            end
`ifdef PATTERN_GAP_EN
            GAP: begin
                if (gap_last) begin
                    state_next = SHIFT;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: values the output registers take at the coming edge
    always_comb begin
        ser_valid_next = (state_next == SHIFT);
        ser_out_next   = ser_valid_next & msb_next;
        done_next      = (state_next == DONE);
        // A zero-repetition job goes straight IDLE -> DONE and never shows busy.
        busy_next      = (state_next == SHIFT) || (state_next == GAP) ||
                         ((state_next == DONE) && (state_reg != IDLE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_out_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            ser_out_reg   <= ser_out_next;
            ser_valid_reg <= ser_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Bit and repetition counters plus the pattern hold copy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_reg <= '0;
            rep_cnt_reg <= '0;
            hold_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        hold_reg    <= bus.pattern;
                        rep_cnt_reg <= bus.reps;
                        bit_cnt_reg <= BIT_W'(PAT_W - 1);
                    end
                end
                SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt_reg <= bit_cnt_reg - BIT_W'(1);
                    end else if (!last_rep) begin
                        rep_cnt_reg <= rep_cnt_reg - CNT_W'(1);
                        bit_cnt_reg <= BIT_W'(PAT_W - 1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ser_out   = ser_out_reg;
    assign bus.ser_valid = ser_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen. Each started job pushes its expected
// per-cycle {ser_valid, ser_out, done, busy} sequence into a queue; a monitor on
// the falling edge pops one entry per cycle and compares. With an empty queue the
// generator must be idle. Also builds with PATTERN_GAP_EN defined.
module tb_seq_pattern_gen;

    localparam int PAT_W    = 4;
    localparam int CNT_W    = 8;
    localparam int GAP_BITS = 2;
`ifdef PATTERN_GAP_EN
    localparam bit GAP_ON = (GAP_BITS != 0);
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef struct packed {
        logic v;
        logic b;
        logic d;
        logic bz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_if ();

    seq_pattern_gen #(
        .PAT_W    (PAT_W),
        .CNT_W    (CNT_W),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t     exp_q[$];
    int       errors = 0;
    int       checks = 0;
    int       done_cnt = 0;
    int       det_hits = 0;
    int       det_len = 0;
    logic [3:0] det_hist = 4'b0;

    // Cycle monitor: scoreboard pop + overlapping 1010 detector on valid bits.
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] obs;
        obs = {bus_if.ser_valid, bus_if.ser_out, bus_if.done, bus_if.busy};
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = '0;
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL cycle_check t=%0t valid/out/done/busy observed=%b required=%b",
                     $time, obs, e);
        end
        if (bus_if.done === 1'b1) done_cnt++;
        if (bus_if.ser_valid === 1'b1) begin
            det_hist = {det_hist[2:0], bus_if.ser_out};
            det_len++;
            if (det_len >= 4 && det_hist == 4'b1010) det_hits++;
        end
    end

    task automatic push_job(input logic [PAT_W-1:0] pat, input int reps_n);
        if (reps_n == 0) begin
            exp_q.push_back('{v:1'b0, b:1'b0, d:1'b1, bz:1'b0});
        end else begin
            for (int r = 0; r < reps_n; r++) begin
                for (int i = PAT_W - 1; i >= 0; i--)
                    exp_q.push_back('{v:1'b1, b:pat[i], d:1'b0, bz:1'b1});
                if (GAP_ON && r != reps_n - 1)
                    for (int g = 0; g < GAP_BITS; g++)
                        exp_q.push_back('{v:1'b0, b:1'b0, d:1'b0, bz:1'b1});
            end
            exp_q.push_back('{v:1'b0, b:1'b0, d:1'b1, bz:1'b1});
        end
        exp_q.push_back('{v:1'b0, b:1'b0, d:1'b0, bz:1'b0});
    endtask

    // Called just after a falling edge: start is sampled at the next rising edge.
    task automatic issue_start(input logic [PAT_W-1:0] pat, input int reps_n);
        bus_if.start   = 1'b1;
        bus_if.pattern = pat;
        bus_if.reps    = CNT_W'(reps_n);
        push_job(pat, reps_n);
        @(posedge clk);
        #1 bus_if.start = 1'b0;
        $display("job start pattern=%b reps=%0d at t=%0t", pat, reps_n, $time);
    endtask

    task automatic start_job(input logic [PAT_W-1:0] pat, input int reps_n);
        @(negedge clk);
        #1;
        issue_start(pat, reps_n);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_done_cnt(input string name, input int required);
        checks++;
        if (done_cnt !== required) begin
            errors++;
            $display("FAIL %s_done_count observed=%0d required=%0d", name, done_cnt, required);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.start   = 1'b1;
        bus_if.pattern = 4'b1010;
        bus_if.reps    = CNT_W'(3);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus_if.ser_valid, bus_if.ser_out, bus_if.done, bus_if.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs observed=%b required=0000",
                     {bus_if.ser_valid, bus_if.ser_out, bus_if.done, bus_if.busy});
        end
        bus_if.start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("test_reset complete");
    endtask

    task automatic test_single();
        done_cnt = 0;
        start_job(4'b1010, 1);
        wait_drain("single");
        check_done_cnt("single", 1);
    endtask

    task automatic test_repeat_detector();
        done_cnt = 0;
        det_hits = 0;
        det_len  = 0;
        det_hist = 4'b0;
        start_job(4'b1010, 3);
        wait_drain("repeat");
        check_done_cnt("repeat", 1);
        checks++;
        if (det_hits !== 5) begin
            errors++;
            $display("FAIL repeat_detector_hits observed=%0d required=5", det_hits);
        end
    endtask

    task automatic test_gap();
        done_cnt = 0;
        start_job(4'b1010, 2);
        wait_drain("gap");
        check_done_cnt("gap", 1);
    endtask

    task automatic test_zero_reps();
        done_cnt = 0;
        start_job(4'b1011, 0);
        wait_drain("zero_reps");
        check_done_cnt("zero_reps", 1);
    endtask

    task automatic test_ignore_start();
        done_cnt = 0;
        start_job(4'b1010, 2);
        @(negedge clk);
        #1;
        bus_if.start   = 1'b1;
        bus_if.pattern = 4'b1111;
        bus_if.reps    = CNT_W'(7);
        @(negedge clk);
        #1;
        bus_if.start = 1'b0;
        wait_drain("ignore_start");
        check_done_cnt("ignore_start", 1);
    endtask

    task automatic test_abort();
        int target;
        int n = 0;
        done_cnt = 0;
        start_job(4'b1010, 2);
        target = exp_q.size() - 2;
        while (exp_q.size() > target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({bus_if.ser_valid, bus_if.ser_out, bus_if.done, bus_if.busy} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_outputs observed=%b required=0000",
                     {bus_if.ser_valid, bus_if.ser_out, bus_if.done, bus_if.busy});
        end
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_done_cnt("abort", 0);
        start_job(4'b0110, 2);
        wait_drain("abort_restart");
        check_done_cnt("abort_restart", 1);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        done_cnt = 0;
        start_job(4'b1100, 1);
        // Wait for the done cycle (only the trailing idle entry left).
        while (exp_q.size() > 1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        #1;
        issue_start(4'b0011, 2);
        wait_drain("back_to_back");
        check_done_cnt("back_to_back", 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            logic [PAT_W-1:0] p;
            int r;
            p = PAT_W'($urandom);
            r = int'($urandom_range(1, 4));
            done_cnt = 0;
            start_job(p, r);
            wait_drain("random");
            check_done_cnt("random", 1);
        end
    endtask

    initial begin
        bus_if.start   = 1'b0;
        bus_if.pattern = '0;
        bus_if.reps    = '0;
        rst            = 1'b1;
        test_reset();
        test_single();
        test_repeat_detector();
        test_gap();
        test_zero_reps();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
